// File: rtl/lsu_byte_sequencer.sv
// Byte-serial load/store initiator: one request in, 1/2/4 little-endian byte
// accesses to a byte-wide data memory, then a single-cycle response.
module lsu_byte_sequencer #(
  parameter logic [31:0] MEM_BASE  = 32'h0000_0400,
  parameter int          MEM_BYTES = 64,
  parameter int          ADDR_W    = 11
) (
  input  logic              sys_clk,
  input  logic              sys_reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_write_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [31:0]       req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_fault_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [7:0]        mem_wdata_o,
  input  logic [7:0]        mem_rdata_i,
  output logic              busy_o,
  output logic [1:0]        dbg_state_o
);

  // Handshake: a request is taken when req_valid_i & req_ready_o at a rising
  // edge; ready is high only in IDLE, and the response has no backpressure.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t              state_q;
  logic [1:0]          byte_idx_q;
  logic [1:0]          last_idx_q;
  logic                write_q;
  logic [2:0]          funct3_q;
  logic [31:0]         wdata_q;
  logic [ADDR_W-1:0]   offset_q;
  logic [31:0]         load_q;
  logic                resp_valid_q;
  logic [31:0]         resp_rdata_q;
  logic                resp_fault_q;

  logic [2:0]          n_bytes_d;
  logic [1:0]          n_last_d;
  logic                f3_ok_d;
  logic [32:0]         off33_d;
  logic [32:0]         end33_d;
  logic                fault_d;
  logic                accept_d;
  logic [31:0]         load_d;
  logic [31:0]         ext_d;
  logic                in_access;

  always_comb begin
    n_bytes_d = 3'd1;
    n_last_d  = 2'd0;
    case (req_funct3_i)
      3'b001, 3'b101: begin n_bytes_d = 3'd2; n_last_d = 2'd1; end
      3'b010:         begin n_bytes_d = 3'd4; n_last_d = 2'd3; end
      default:        begin n_bytes_d = 3'd1; n_last_d = 2'd0; end
    endcase
    if (req_write_i)
      f3_ok_d = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010);
    else
      f3_ok_d = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) || (req_funct3_i == 3'b010)
             || (req_funct3_i == 3'b100) || (req_funct3_i == 3'b101);
    // 33-bit arithmetic so an address near 2^32 cannot wrap back into the window
    off33_d  = {1'b0, req_addr_i} - {1'b0, MEM_BASE};
    end33_d  = off33_d + {30'd0, n_bytes_d};
    fault_d  = !f3_ok_d || (req_addr_i < MEM_BASE) || (end33_d > 33'(MEM_BYTES));
    accept_d = req_valid_i && req_ready_o;
  end

  always_comb begin
    load_d = load_q;
    load_d[{byte_idx_q, 3'b000} +: 8] = mem_rdata_i;
    case (funct3_q)
      3'b000:  ext_d = {{24{load_d[7]}}, load_d[7:0]};
      3'b100:  ext_d = {24'd0, load_d[7:0]};
      3'b001:  ext_d = {{16{load_d[15]}}, load_d[15:0]};
      3'b101:  ext_d = {16'd0, load_d[15:0]};
      default: ext_d = load_d;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_q      <= S_IDLE;
      byte_idx_q   <= '0;
      last_idx_q   <= '0;
      write_q      <= 1'b0;
      funct3_q     <= '0;
      wdata_q      <= '0;
      offset_q     <= '0;
      load_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept_d) begin
            write_q    <= req_write_i;
            funct3_q   <= req_funct3_i;
            wdata_q    <= req_wdata_i;
            offset_q   <= off33_d[ADDR_W-1:0];
            byte_idx_q <= '0;
            last_idx_q <= n_last_d;
            load_q     <= '0;
            if (fault_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_fault_q <= 1'b1;
            end else begin
              state_q <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (!write_q) load_q <= load_d;
          byte_idx_q <= byte_idx_q + 2'd1;
          if (byte_idx_q == last_idx_q) begin
            state_q      <= S_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= write_q ? 32'd0 : ext_d;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_access    = (state_q == S_ACCESS);
  assign mem_addr_o   = in_access ? offset_q + ADDR_W'(byte_idx_q) : '0;
  assign mem_we_o     = in_access && write_q;
  assign mem_re_o     = in_access && !write_q;
  assign mem_wdata_o  = (in_access && write_q) ? wdata_q[{byte_idx_q, 3'b000} +: 8] : 8'd0;
  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign dbg_state_o  = state_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign resp_fault_o = resp_fault_q;

endmodule
